// File: rtl/fifo_param_pkg.sv
// Shared definitions for the parametrised switch/bridge port buffer.
// DATA_WIDTH mirrors the project-wide datapath width.
package fifo_param_pkg;

  localparam int DATA_WIDTH = 32;

  // Occupancy field width for a buffer of the given depth (0..depth).
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Port bundle for fifo_param: enq/deq handshake, flush, and status outputs.
// enq is refused only when busy; deq is honoured only when valid; both are same-cycle combinational.
interface fifo_param_if
  import fifo_param_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH + 1,
  parameter int DEPTH = 4
) ();

  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] d_in;
  logic             enq;
  logic             deq;
  logic             flush;
  logic [WIDTH-1:0] d_out;
  logic             valid;
  logic             busy;
  logic             c_out;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             udf;

  modport master (
    output d_in, enq, deq, flush,
    input  d_out, valid, busy, c_out, count, ovf, udf
  );

  modport slave (
    input  d_in, enq, deq, flush,
    output d_out, valid, busy, c_out, count, ovf, udf
  );

endinterface

// File: rtl/fifo_param_ptr.sv
// Wrapping pointer 0..DEPTH-1 for the circular buffer; clr returns it to slot 0.
module fifo_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q, ptr_d;

  // Explicit wrap so non-power-of-two depths work.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_param.sv
// Single-clock FIFO with first-word bypass, overflow guard, credit output,
// synchronous flush, occupancy output and sticky overflow/underflow flags.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int WIDTH        = DATA_WIDTH + 1,
  parameter int DEPTH        = 4,
  parameter int CREDIT_SLACK = 1,
  parameter int BYPASS       = 1,
  parameter int ID           = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  fifo_param_if.slave  io
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic BYP_EN = (BYPASS != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [PW-1:0]    rp, wp;

  logic empty, full, byp, wr, rd;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));
    byp   = BYP_EN & empty & io.enq & io.deq;
    wr    = io.enq & ~io.busy & ~byp;
    rd    = io.deq & ~empty;
  end

  assign io.valid = io.deq & (~empty | byp);
  assign io.busy  = io.enq & full & ~io.deq;
  assign io.d_out = byp ? io.d_in : (empty ? '0 : mem_q[rp]);
  assign io.count = count_q;
  assign io.c_out = (32'(count_q) + 32'(CREDIT_SLACK)) < 32'(DEPTH);
  assign io.ovf   = ovf_q;
  assign io.udf   = udf_q;

  fifo_ptr #(.DEPTH(DEPTH)) u_rp (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (io.flush),
    .inc   (rd),
    .ptr   (rp)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_wp (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (io.flush),
    .inc   (wr),
    .ptr   (wp)
  );

  // A flush cycle swallows that cycle's enq/deq, including their error flags.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (io.flush) begin
      count_d = '0;
    end else begin
      if (wr && !rd) begin
        count_d = count_q + CW'(1);
      end else if (rd && !wr) begin
        count_d = count_q - CW'(1);
      end
      if (io.busy) begin
        ovf_d = 1'b1;
      end
      if (io.deq && empty && !byp) begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately unreset; count gates what is visible.
  always_ff @(posedge clk) begin
    if (rst_n && !io.flush && wr) begin
      mem_q[wp] <= io.d_in;
    end
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised single-clock FIFO with first-word bypass, overflow guard, and a configurable credit (almost-full) output. It is the general buffer for DySER switch and bridge ports: same enq/deq/valid/busy/c_out contract as the fixed 4-entry buffer, but with width, depth and credit slack set per instance. It also adds synchronous flush, occupancy output and sticky error flags.

## Interface
- `WIDTH`, default `DATA_WIDTH+1` (from `config.v`): payload bits per entry.
- `DEPTH`, default 4: entries, any value ≥ 2 (power of two not required).
- `CREDIT_SLACK`, default 1: free entries required to keep `c_out` high.
- `BYPASS`, default 1: 1 lets `d_in` pass through combinationally when empty with enq&deq; 0 disables bypass.
- `ID`, default 0: instance tag, no functional effect.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `d_in`  in  WIDTH  write data.
- `enq`  in  1  write request.
- `deq`  in  1  read request; pops the head this cycle if `valid`.
- `flush`  in  1  synchronous clear of contents.
- `d_out`  out  WIDTH  head data, or bypassed `d_in`.
- `valid`  out  1  `deq` is being honoured this cycle.
- `busy`  out  1  `enq` is being rejected this cycle.
- `c_out`  out  1  credit: upstream may issue.
- `count`  out  CW  occupancy, CW = clog2(DEPTH+1).
- `ovf`  out  1  sticky: an enq was dropped.
- `udf`  out  1  sticky: a deq found no data.

## Operation
- Storage is a circular buffer with read pointer `rp` and write pointer `wp`, each 0..DEPTH-1. Pointers wrap explicitly from DEPTH-1 to 0. `count` is held in a register; no full/empty derivation from the pointers.
- empty = (count==0); full = (count==DEPTH).
- Bypass case (`byp`) = BYPASS & empty & enq & deq. `d_out` = `d_in`, `valid` = 1, nothing is stored, and pointers and count are unchanged.
- `valid` = deq & (~empty | byp).
- `busy` = enq & full & ~deq. A rejected write is dropped and sets `ovf`.
- Accepted write (wr) = enq & ~busy & ~byp: writes `mem[wp]` and advances `wp`.
- Accepted read (rd) = deq & ~empty: advances `rp`.
- Count update: wr & ~rd gives +1; rd & ~wr gives −1; otherwise unchanged. When full, enq&deq pops the head and writes the new entry in the freed slot in the same cycle.
- deq & empty & ~byp: `valid`=0, no state change, sets `udf`. This includes deq on empty with enq when BYPASS=0; the enq is stored in that case.
- `d_out` = 0 whenever no data is presented, i.e. empty & ~byp. Storage itself is not reset.
- `c_out` = (count + CREDIT_SLACK < DEPTH). With DEPTH 4 and slack 1 it is high for count ≤ 2.
- `flush`: next cycle count=0, rp=wp=0, and the same-cycle enq/deq take no effect. Combinational outputs in the flush cycle still follow the current state. `ovf`/`udf` are not cleared by flush.
- Reset (`rst_n`=0 at an edge): count=0, rp=wp=0, ovf=udf=0. This takes priority over flush, enq and deq. After reset `d_out`=0, `valid`=0, `busy`=0, `c_out`=1 (for CREDIT_SLACK < DEPTH).

## Timing
- All state updates on the rising edge of `clk`.
- `valid`, `busy` and `d_out` are combinational from current state and inputs, including the `d_in`→`d_out` bypass path. `c_out` and `count` depend only on registered state.
- Write-to-read latency: 1 cycle through storage, 0 cycles with bypass.
- Throughput: one enq and one deq per cycle at any occupancy.
- Reset asserted mid-stream discards all contents at that edge; outputs show the reset values from the next cycle.

## Structure
- One module plus one sub-module, `fifo_ptr`: a wrapping pointer counter (DEPTH, inc → ptr), instantiated twice.
- `DATA_WIDTH` comes from the shared `config.v`.
- No new shared constants: clog2 widths are computed locally.

## Test plan
- Reset, then DEPTH=4: enq 0xA,0xB,0xC,0xD on consecutive cycles → count 1..4; `c_out` falls after the third write; `busy` only on a fifth enq with deq=0; fifth value dropped; `ovf`=1.
- Full FIFO, enq 0xE & deq for 3 cycles → `valid`=1 with d_out 0xA,0xB,0xC; count stays 4; order after drain is D,E,…
- Empty FIFO, BYPASS=1, enq 0x5 & deq → d_out=0x5, valid=1, count stays 0. Repeat with BYPASS=0 → valid=0, udf=1, count=1, next-cycle deq gives 0x5.
- DEPTH=5, 12 alternating enq/deq bursts crossing the wrap point → FIFO order preserved; count never exceeds 5.
- Count 3, flush with enq&deq asserted → next cycle count=0, d_out=0, c_out=1; the enq value is not stored.
- Count 2, `rst_n` low for one cycle with enq held → count=0, ovf=udf=0, valid=0; the enq is not stored.
